// File: rtl/blind_pkg.sv
// ---------------------------------------------------------------------------
// blind_pkg
// Shared definitions for the blind command arbiter:
//   - position command encodings driven on P
//   - requester IDs reported on fuente
//   - arbiter FSM state encoding
//   - sensor_hit(): selects the position sensor that confirms a given target
// ---------------------------------------------------------------------------
package blind_pkg;

    // Position commands (2'b11 is not a legal target and is discarded)
    localparam logic [1:0] POS_INF = 2'b00;
    localparam logic [1:0] POS_MED = 2'b01;
    localparam logic [1:0] POS_SUP = 2'b10;
    localparam logic [1:0] POS_BAD = 2'b11;

    // Requester that produced the last grant
    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_MAN  = 2'b01;
    localparam logic [1:0] SRC_LUZ  = 2'b10;
    localparam logic [1:0] SRC_HOR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MOVE  = 2'b01,
        ST_HOLD  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    // True when the sensor belonging to the commanded position is active.
    function automatic logic sensor_hit(input logic [1:0] pos,
                                        input logic s_inf,
                                        input logic s_med,
                                        input logic s_sup);
        case (pos)
            POS_INF: sensor_hit = s_inf;
            POS_MED: sensor_hit = s_med;
            POS_SUP: sensor_hit = s_sup;
            default: sensor_hit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/blind_debounce.sv
// ---------------------------------------------------------------------------
// blind_debounce
// Level filter for one (already synchronised) button. The output follows the
// input only after CYCLES consecutive samples that differ from the current
// output; any sample equal to the output restarts the count.
// Ports:
//   reloj  in  clock
//   reset  in  asynchronous active-high reset (output and count cleared)
//   din    in  synchronised button level
//   dout   out filtered, stable button level
// ---------------------------------------------------------------------------
module blind_debounce #(
    parameter int CYCLES = 16
) (
    input  logic reloj,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [15:0] CNT_LAST = 16'(CYCLES - 1);

    logic [15:0] cnt_q;
    logic        dout_q;

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            cnt_q  <= 16'd0;
            dout_q <= 1'b0;
        end else if (din == dout_q) begin
            cnt_q <= 16'd0;
        end else if (cnt_q >= CNT_LAST) begin
            dout_q <= din;
            cnt_q  <= 16'd0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/blind_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// blind_cmd_arbiter
// Arbitrates position requests from manual buttons, light automation and the
// schedule, drives the blind position command P, watches the position sensors
// for arrival and raises falla when a move does not finish in time.
// Optional feature macro: BLIND_DEBOUNCE_EN (adds blind_debounce per button).
// Ports:
//   reloj, reset                 clock, asynchronous active-high reset
//   btn_sub/btn_med/btn_baj      manual levels for top/middle/bottom
//   luz_req, luz_pos[1:0]        light request pulse and target
//   hor_req, hor_pos[1:0]        schedule request pulse and target
//   Ssup, Smed, Sinf             top/middle/bottom position sensors
//   P[1:0]                       position command (00 bottom, 01 mid, 10 top)
//   ocupado                      high while moving
//   falla                        high in fault
//   fuente[1:0]                  source of last grant
//   hecho                        one-cycle arrival pulse
// ---------------------------------------------------------------------------
module blind_cmd_arbiter
    import blind_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int HOLD_CYCLES     = 4096
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       btn_sub,
    input  logic       btn_med,
    input  logic       btn_baj,
    input  logic       luz_req,
    input  logic [1:0] luz_pos,
    input  logic       hor_req,
    input  logic [1:0] hor_pos,
    input  logic       Ssup,
    input  logic       Smed,
    input  logic       Sinf,
    output logic [1:0] P,
    output logic       ocupado,
    output logic       falla,
    output logic [1:0] fuente,
    output logic       hecho
);

    // The shared counter is 16 bits wide, so every interval must fit in it.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
        TIMEOUT_CYCLES  < 1 || TIMEOUT_CYCLES  > 65535 ||
        HOLD_CYCLES     < 1 || HOLD_CYCLES     > 65535) begin : g_bad_params
        $error("blind_cmd_arbiter: cycle parameters must be in 1..65535");
    end

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);

    // ---------------- manual button conditioning ----------------
    // Bit order: [2] top, [1] middle, [0] bottom
    logic [2:0] btn_raw;
    logic [2:0] sync0_q, sync1_q;
    logic [2:0] level;
    logic [2:0] level_prev_q;
    logic [2:0] rise;

    assign btn_raw = {btn_sub, btn_med, btn_baj};

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            sync0_q      <= 3'b000;
            sync1_q      <= 3'b000;
            level_prev_q <= 3'b000;
        end else begin
            sync0_q      <= btn_raw;
            sync1_q      <= sync0_q;
            level_prev_q <= level;
        end
    end

`ifdef BLIND_DEBOUNCE_EN
    for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
        blind_debounce #(
            .CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .reloj (reloj),
            .reset (reset),
            .din   (sync1_q[gi]),
            .dout  (level[gi])
        );
    end
`else
    assign level = sync1_q;
`endif

    assign rise = level & ~level_prev_q;

    logic       man_req;
    logic [1:0] man_pos;

    always_comb begin
        man_req = |rise;
        man_pos = POS_INF;
        if (rise[2])      man_pos = POS_SUP;
        else if (rise[1]) man_pos = POS_MED;
    end

    // ---------------- state and pending registers ----------------
    state_t      state_q;
    logic [1:0]  p_q;
    logic        ocupado_q, falla_q, hecho_q;
    logic [1:0]  fuente_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        man_v_q, luz_v_q, hor_v_q;
    logic [1:0]  man_t_q, luz_t_q, hor_t_q;

    // Counter saturates instead of wrapping.
    assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // Fixed-priority pick among pending entries (used in IDLE).
    logic       sel_v;
    logic [1:0] sel_t;
    logic [1:0] sel_src;

    always_comb begin
        sel_v   = 1'b0;
        sel_t   = POS_INF;
        sel_src = SRC_NONE;
        if (man_v_q) begin
            sel_v = 1'b1; sel_t = man_t_q; sel_src = SRC_MAN;
        end else if (luz_v_q) begin
            sel_v = 1'b1; sel_t = luz_t_q; sel_src = SRC_LUZ;
        end else if (hor_v_q) begin
            sel_v = 1'b1; sel_t = hor_t_q; sel_src = SRC_HOR;
        end
    end

    logic arrive;
    logic accept_auto;

    assign arrive      = sensor_hit(p_q, Sinf, Smed, Ssup);
    assign accept_auto = (state_q == ST_IDLE) || (state_q == ST_MOVE);

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            p_q       <= POS_INF;
            ocupado_q <= 1'b0;
            falla_q   <= 1'b0;
            fuente_q  <= SRC_NONE;
            hecho_q   <= 1'b0;
            cnt_q     <= 16'd0;
            man_v_q   <= 1'b0;
            luz_v_q   <= 1'b0;
            hor_v_q   <= 1'b0;
            man_t_q   <= POS_INF;
            luz_t_q   <= POS_INF;
            hor_t_q   <= POS_INF;
        end else begin
            hecho_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_v) begin
                        case (sel_src)
                            SRC_MAN: man_v_q <= 1'b0;
                            SRC_LUZ: luz_v_q <= 1'b0;
                            default: hor_v_q <= 1'b0;
                        endcase
                        if (sel_t != p_q) begin
                            p_q       <= sel_t;
                            fuente_q  <= sel_src;
                            ocupado_q <= 1'b1;
                            cnt_q     <= 16'd0;
                            state_q   <= ST_MOVE;
                        end
                    end
                end
                ST_MOVE: begin
                    if (arrive) begin
                        hecho_q   <= 1'b1;
                        ocupado_q <= 1'b0;
                        cnt_q     <= 16'd0;
                        state_q   <= (fuente_q == SRC_MAN) ? ST_HOLD : ST_IDLE;
                    end else if (man_v_q) begin
                        // Manual preemption: retarget and restart the timeout.
                        man_v_q  <= 1'b0;
                        p_q      <= man_t_q;
                        fuente_q <= SRC_MAN;
                        cnt_q    <= 16'd0;
                    end else if (cnt_q >= TIMEOUT_LAST) begin
                        ocupado_q <= 1'b0;
                        falla_q   <= 1'b1;
                        state_q   <= ST_FAULT;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_HOLD: begin
                    if (man_v_q && man_t_q != p_q) begin
                        man_v_q   <= 1'b0;
                        p_q       <= man_t_q;
                        fuente_q  <= SRC_MAN;
                        ocupado_q <= 1'b1;
                        cnt_q     <= 16'd0;
                        state_q   <= ST_MOVE;
                    end else begin
                        man_v_q <= 1'b0;
                        if (cnt_q >= HOLD_LAST) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: begin // ST_FAULT: P held until a manual request
                    if (man_v_q) begin
                        man_v_q   <= 1'b0;
                        p_q       <= man_t_q;
                        fuente_q  <= SRC_MAN;
                        ocupado_q <= 1'b1;
                        falla_q   <= 1'b0;
                        cnt_q     <= 16'd0;
                        state_q   <= ST_MOVE;
                    end
                end
            endcase

            // New requests are written after the FSM so that a request landing
            // in the same cycle its entry is cleared survives.
            if (man_req) begin
                man_v_q <= 1'b1;
                man_t_q <= man_pos;
            end
            if (!accept_auto) begin
                luz_v_q <= 1'b0;
                hor_v_q <= 1'b0;
            end else begin
                if (luz_req && luz_pos != POS_BAD) begin
                    luz_v_q <= 1'b1;
                    luz_t_q <= luz_pos;
                end
                if (hor_req && hor_pos != POS_BAD) begin
                    hor_v_q <= 1'b1;
                    hor_t_q <= hor_pos;
                end
            end
        end
    end

    assign P       = p_q;
    assign ocupado = ocupado_q;
    assign falla   = falla_q;
    assign fuente  = fuente_q;
    assign hecho   = hecho_q;

endmodule

// File: tb/tb_blind_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_blind_cmd_arbiter
// Directed and randomized transactions on blind_cmd_arbiter. Expected values
// come from a transaction-level model (m_p / m_src): a request either moves
// the blind to a new target or leaves everything unchanged.
// ---------------------------------------------------------------------------
module tb_blind_cmd_arbiter;

    localparam int DEB  = 8;
    localparam int TOUT = 20;
    localparam int HOLD = 40;

    logic       reloj = 1'b0;
    logic       reset = 1'b1;
    logic       btn_sub = 1'b0, btn_med = 1'b0, btn_baj = 1'b0;
    logic       luz_req = 1'b0, hor_req = 1'b0;
    logic [1:0] luz_pos = 2'b00, hor_pos = 2'b00;
    logic       Ssup = 1'b0, Smed = 1'b0, Sinf = 1'b0;
    logic [1:0] P;
    logic       ocupado, falla, hecho;
    logic [1:0] fuente;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [1:0] m_p   = 2'b00;
    logic [1:0] m_src = 2'b00;

    blind_cmd_arbiter #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TOUT),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .reloj   (reloj),
        .reset   (reset),
        .btn_sub (btn_sub),
        .btn_med (btn_med),
        .btn_baj (btn_baj),
        .luz_req (luz_req),
        .luz_pos (luz_pos),
        .hor_req (hor_req),
        .hor_pos (hor_pos),
        .Ssup    (Ssup),
        .Smed    (Smed),
        .Sinf    (Sinf),
        .P       (P),
        .ocupado (ocupado),
        .falla   (falla),
        .fuente  (fuente),
        .hecho   (hecho)
    );

    always #5 reloj = ~reloj;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_p(input string tag, input logic [1:0] exp, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (P === exp) break;
            tick();
        end
        chk(tag, P, exp);
    endtask

    task automatic set_sensor(input logic [1:0] pos, input logic val);
        Sinf = 1'b0; Smed = 1'b0; Ssup = 1'b0;
        case (pos)
            2'b00: Sinf = val;
            2'b01: Smed = val;
            2'b10: Ssup = val;
            default: ;
        endcase
    endtask

    // One light (is_hor=0) or schedule (is_hor=1) request checked end to end.
    task automatic auto_req(input bit is_hor, input logic [1:0] tgt, input int dly);
        logic [1:0] src;
        logic [1:0] other;
        src = is_hor ? 2'b11 : 2'b10;
        if (is_hor) begin hor_req = 1'b1; hor_pos = tgt; end
        else        begin luz_req = 1'b1; luz_pos = tgt; end
        tick();
        luz_req = 1'b0; hor_req = 1'b0;
        chk("p_before_grant", P, m_p);
        tick();
        if (tgt == 2'b11 || tgt == m_p) begin
            chk("nomove_ocupado", {1'b0, ocupado}, 2'b00);
            chk("nomove_p", P, m_p);
            chk("nomove_fuente", fuente, m_src);
            tick();
            chk("nomove_hecho", {1'b0, hecho}, 2'b00);
        end else begin
            chk("grant_p", P, tgt);
            chk("grant_ocupado", {1'b0, ocupado}, 2'b01);
            chk("grant_fuente", fuente, src);
            m_p = tgt;
            m_src = src;
            for (int i = 0; i < dly; i++) begin
                other = 2'($urandom_range(0, 3));
                if (other != tgt) set_sensor(other, 1'b1);
                else              set_sensor(2'b11, 1'b0);
                tick();
                chk("moving_ocupado", {1'b0, ocupado}, 2'b01);
            end
            set_sensor(tgt, 1'b1);
            tick();
            chk("arrive_hecho", {1'b0, hecho}, 2'b01);
            chk("arrive_ocupado", {1'b0, ocupado}, 2'b00);
            set_sensor(2'b11, 1'b0);
            tick();
            chk("after_hecho", {1'b0, hecho}, 2'b00);
        end
        $display("txn src=%0d tgt=%0d dly=%0d -> P=%0d fuente=%0d", src, tgt, dly, P, fuente);
    endtask

    initial begin
        logic [1:0] tgt;
        // ---------- reset ----------
        tick();
        chk("rst_p", P, 2'b00);
        chk("rst_ocupado", {1'b0, ocupado}, 2'b00);
        chk("rst_falla", {1'b0, falla}, 2'b00);
        chk("rst_fuente", fuente, 2'b00);
        chk("rst_hecho", {1'b0, hecho}, 2'b00);
        reset = 1'b0;
        tick();

        // ---------- light to top, sensor 5 cycles later ----------
        auto_req(1'b0, 2'b10, 5);

        // ---------- simultaneous light(01) and schedule(00) ----------
        luz_req = 1'b1; luz_pos = 2'b01; hor_req = 1'b1; hor_pos = 2'b00;
        tick();
        luz_req = 1'b0; hor_req = 1'b0;
        tick();
        chk("simul_p_luz", P, 2'b01);
        chk("simul_fuente_luz", fuente, 2'b10);
        set_sensor(2'b01, 1'b1);
        tick();
        chk("simul_hecho1", {1'b0, hecho}, 2'b01);
        set_sensor(2'b11, 1'b0);
        tick();
        chk("simul_p_hor", P, 2'b00);
        chk("simul_fuente_hor", fuente, 2'b11);
        chk("simul_ocupado_hor", {1'b0, ocupado}, 2'b01);
        set_sensor(2'b00, 1'b1);
        tick();
        chk("simul_hecho2", {1'b0, hecho}, 2'b01);
        set_sensor(2'b11, 1'b0);
        tick();
        m_p = 2'b00; m_src = 2'b11;
        $display("txn simultaneous luz/hor -> P=%0d fuente=%0d", P, fuente);

        // ---------- equal target, illegal target, stale-pending check ----------
        auto_req(1'b0, 2'b00, 0);
        auto_req(1'b1, 2'b11, 0);
        auto_req(1'b1, 2'b10, 1);
        tick(); tick();
        chk("no_stale_p", P, 2'b10);
        chk("no_stale_ocupado", {1'b0, ocupado}, 2'b00);

        // ---------- randomized light/schedule traffic ----------
        for (int k = 0; k < 24; k++) begin
            auto_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     int'($urandom_range(0, 8)));
        end

        // ---------- manual preemption, then HOLD discards automation ----------
        if (m_p == 2'b10) auto_req(1'b0, 2'b00, 1);
        luz_req = 1'b1; luz_pos = 2'b10;
        tick();
        luz_req = 1'b0;
        tick();
        chk("pre_p", P, 2'b10);
        repeat (2) tick();
        btn_baj = 1'b1;
        wait_p("preempt_p", 2'b00, 24);
        chk("preempt_fuente", fuente, 2'b01);
        chk("preempt_ocupado", {1'b0, ocupado}, 2'b01);
        repeat (15) tick();
        chk("restart_falla", {1'b0, falla}, 2'b00);
        set_sensor(2'b00, 1'b1);
        tick();
        chk("man_hecho", {1'b0, hecho}, 2'b01);
        chk("man_ocupado", {1'b0, ocupado}, 2'b00);
        set_sensor(2'b11, 1'b0);
        tick();
        hor_req = 1'b1; hor_pos = 2'b10;
        tick();
        hor_req = 1'b0;
        repeat (3) tick();
        chk("hold_ocupado", {1'b0, ocupado}, 2'b00);
        repeat (50) tick();
        chk("hold_drop_p", P, 2'b00);
        chk("hold_drop_ocupado", {1'b0, ocupado}, 2'b00);
        btn_baj = 1'b0;
        repeat (20) tick();
        m_p = 2'b00; m_src = 2'b01;
        $display("txn manual preempt + hold -> P=%0d fuente=%0d", P, fuente);
        auto_req(1'b0, 2'b01, 2);

        // ---------- timeout into FAULT and manual recovery ----------
        tgt = (m_p == 2'b10) ? 2'b00 : 2'b10;
        luz_req = 1'b1; luz_pos = tgt;
        tick();
        luz_req = 1'b0;
        tick();
        chk("to_p", P, tgt);
        repeat (TOUT - 1) tick();
        chk("to_falla_early", {1'b0, falla}, 2'b00);
        chk("to_ocupado_early", {1'b0, ocupado}, 2'b01);
        tick();
        chk("to_falla", {1'b0, falla}, 2'b01);
        chk("to_ocupado", {1'b0, ocupado}, 2'b00);
        chk("to_p_held", P, tgt);
        luz_req = 1'b1; luz_pos = 2'b01;
        tick();
        luz_req = 1'b0;
        repeat (4) tick();
        chk("fault_ignore_p", P, tgt);
        chk("fault_ignore_falla", {1'b0, falla}, 2'b01);
        btn_med = 1'b1;
        wait_p("fault_clear_p", 2'b01, 24);
        chk("fault_clear_falla", {1'b0, falla}, 2'b00);
        chk("fault_clear_ocupado", {1'b0, ocupado}, 2'b01);
        chk("fault_clear_fuente", fuente, 2'b01);
        set_sensor(2'b01, 1'b1);
        tick();
        chk("fault_rec_hecho", {1'b0, hecho}, 2'b01);
        set_sensor(2'b11, 1'b0);
        btn_med = 1'b0;
        repeat (HOLD + 20) tick();
        m_p = 2'b01; m_src = 2'b01;
        $display("txn timeout + recovery -> P=%0d falla=%0d", P, falla);

        // ---------- asynchronous reset mid-move ----------
        luz_req = 1'b1; luz_pos = 2'b10;
        tick();
        luz_req = 1'b0;
        tick();
        chk("rm_p_move", P, 2'b10);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_p", P, 2'b00);
        chk("rm_ocupado", {1'b0, ocupado}, 2'b00);
        chk("rm_falla", {1'b0, falla}, 2'b00);
        chk("rm_fuente", fuente, 2'b00);
        chk("rm_hecho", {1'b0, hecho}, 2'b00);
        tick();
        reset = 1'b0;
        tick();
        chk("rm_p_after", P, 2'b00);
        m_p = 2'b00; m_src = 2'b00;
        $display("txn reset mid-move -> P=%0d", P);

`ifdef BLIND_DEBOUNCE_EN
        // ---------- short glitch must be filtered ----------
        btn_sub = 1'b1;
        repeat (5) tick();
        btn_sub = 1'b0;
        repeat (20) tick();
        chk("glitch_p", P, 2'b00);
        chk("glitch_ocupado", {1'b0, ocupado}, 2'b00);
        $display("txn debounce glitch -> P=%0d", P);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
